// File: rtl/fifos_if_pkg.sv
// Flit-format constants and arbiter state encoding shared by the send-request
// path (arbiter and FIFO interface).
package fifos_if_pkg;

    localparam int DATA_LINE_WIDTH    = 64;
    localparam int CONTROL_LINE_WIDTH = 6;
    localparam int TAIL_BIT           = 0;
    localparam int W                  = DATA_LINE_WIDTH + CONTROL_LINE_WIDTH;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } arb_state_e;

endpackage

// File: rtl/rr_priority_pick.sv
// Rotating priority encoder: the first set request at or after ptr_i, wrapping
// modulo N, wins. Purely combinational.
module rr_priority_pick #(
    parameter int N    = 4,
    parameter int LOGN = 2
) (
    input  logic [N-1:0]    req_i,
    input  logic [LOGN-1:0] ptr_i,
    output logic [N-1:0]    gnt_o,
    output logic [LOGN-1:0] idx_o,
    output logic            found_o
);

    always_comb begin
        gnt_o   = '0;
        idx_o   = '0;
        found_o = 1'b0;
        // Walk from farthest to nearest so the lowest offset from ptr_i wins.
        for (int i = N - 1; i >= 0; i--) begin
            if (req_i[(int'(ptr_i) + i) % N]) begin
                idx_o   = LOGN'((int'(ptr_i) + i) % N);
                found_o = 1'b1;
            end
        end
        if (found_o) gnt_o[idx_o] = 1'b1;
    end

endmodule

// File: rtl/fifo_req_arbiter.sv
// Packet-aware round-robin arbiter in front of the send-request FIFO write
// port; holds the grant from head flit to tail flit so packets never interleave.
module fifo_req_arbiter
    import fifos_if_pkg::*;
#(
    parameter int NUM_REQ            = 4,
    parameter int LOG2_NUM_REQ       = 2,
    parameter int DATA_LINE_WIDTH    = fifos_if_pkg::DATA_LINE_WIDTH,
    parameter int CONTROL_LINE_WIDTH = fifos_if_pkg::CONTROL_LINE_WIDTH,
    parameter int TAIL_BIT           = fifos_if_pkg::TAIL_BIT,
    localparam int FW                = DATA_LINE_WIDTH + CONTROL_LINE_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    i_req_valid,
    input  logic [NUM_REQ*FW-1:0] i_req_bits,
    output logic [NUM_REQ-1:0]    o_req_ready,
    output logic [FW-1:0]         o_sreq_inbits,
    output logic                  o_sreq_wen,
    input  logic                  i_sreq_fifo_full,
    output logic [NUM_REQ-1:0]    o_grant,
    output logic                  o_locked,
    output logic [15:0]           o_pkt_count
);

    arb_state_e              state_q, state_d;
    logic [LOG2_NUM_REQ-1:0] owner_q, owner_d;
    logic [LOG2_NUM_REQ-1:0] rr_ptr_q, rr_ptr_d;
    logic [15:0]             pkt_count_q, pkt_count_d;

    logic [NUM_REQ-1:0]      pick_gnt;
    logic [LOG2_NUM_REQ-1:0] pick_idx;
    logic                    pick_found;

    logic [FW-1:0]           req_flit [NUM_REQ];
    logic [NUM_REQ-1:0]      grant;
    logic [LOG2_NUM_REQ-1:0] gidx;
    logic                    has_grant;
    logic [FW-1:0]           sel_flit;
    logic                    wen;
    logic                    is_tail;
    logic [LOG2_NUM_REQ-1:0] gidx_next;

    rr_priority_pick #(
        .N    (NUM_REQ),
        .LOGN (LOG2_NUM_REQ)
    ) u_pick (
        .req_i   (i_req_valid),
        .ptr_i   (rr_ptr_q),
        .gnt_o   (pick_gnt),
        .idx_o   (pick_idx),
        .found_o (pick_found)
    );

    always_comb begin
        for (int k = 0; k < NUM_REQ; k++) req_flit[k] = i_req_bits[k*FW +: FW];
    end

    always_comb begin
        grant     = '0;
        gidx      = pick_idx;
        has_grant = pick_found;
        if (state_q == LOCKED) begin
            gidx        = owner_q;
            has_grant   = 1'b1;
            grant[gidx] = 1'b1;
        end else begin
            grant = pick_gnt;
        end
        sel_flit  = has_grant ? req_flit[gidx] : '0;
        wen       = (|(i_req_valid & grant)) && !i_sreq_fifo_full;
        is_tail   = sel_flit[DATA_LINE_WIDTH + TAIL_BIT];
        gidx_next = (gidx == LOG2_NUM_REQ'(NUM_REQ - 1)) ? '0
                                                          : gidx + LOG2_NUM_REQ'(1);
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        pkt_count_d = pkt_count_q;
        if (wen) begin
            if (is_tail) begin
                state_d     = IDLE;
                rr_ptr_d    = gidx_next;
                pkt_count_d = pkt_count_q + 16'd1;
            end else begin
                state_d = LOCKED;
                owner_d = gidx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    // Outputs are forced quiet while reset is held, independent of requesters.
    always_comb begin
        o_grant       = rst ? '0 : grant;
        o_sreq_wen    = rst ? 1'b0 : wen;
        o_req_ready   = rst ? '0 : (grant & {NUM_REQ{wen}});
        o_sreq_inbits = rst ? '0 : sel_flit;
        o_locked      = rst ? 1'b0 : (state_q == LOCKED);
        o_pkt_count   = rst ? '0 : pkt_count_q;
    end

endmodule

// File: tb/tb_fifo_req_arbiter.sv
// Directed bench for fifo_req_arbiter: reset, rotation, packet lock, bubble,
// full stall and reset mid-packet with pointer wrap.
module tb_fifo_req_arbiter;

    localparam int N  = 4;
    localparam int FW = 70;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    valid;
    logic [N*FW-1:0] bits;
    logic [N-1:0]    ready;
    logic [FW-1:0]   inbits;
    logic            wen;
    logic            full;
    logic [N-1:0]    grant;
    logic            locked;
    logic [15:0]     pkt_count;
    logic [FW-1:0]   fl [N];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    assign bits = {fl[3], fl[2], fl[1], fl[0]};

    fifo_req_arbiter dut (
        .clk              (clk),
        .rst              (rst),
        .i_req_valid      (valid),
        .i_req_bits       (bits),
        .o_req_ready      (ready),
        .o_sreq_inbits    (inbits),
        .o_sreq_wen       (wen),
        .i_sreq_fifo_full (full),
        .o_grant          (grant),
        .o_locked         (locked),
        .o_pkt_count      (pkt_count)
    );

    function automatic logic [FW-1:0] mk(input logic [63:0] d, input logic tail);
        return {5'b0, tail, d};
    endfunction

    task automatic chk(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst   = 1'b1;
        full  = 1'b0;
        valid = 4'b1111;
        for (int k = 0; k < N; k++) fl[k] = mk(64'hA0 + 64'(k), 1'b1);
        #3;
        chk("rst_grant",  FW'(grant), '0);
        chk("rst_ready",  FW'(ready), '0);
        chk("rst_wen",    FW'(wen), '0);
        chk("rst_inbits", inbits, '0);
        chk("rst_locked", FW'(locked), '0);
        chk("rst_cnt",    FW'(pkt_count), '0);
        tick();
        rst = 1'b0;
        #1;

        // Continuous single-flit packets rotate 0,1,2,3,0.
        for (int i = 0; i < 5; i++) begin
            chk("rr_grant",  FW'(grant), FW'(1 << (i % 4)));
            chk("rr_wen",    FW'(wen), 1);
            chk("rr_inbits", inbits, mk(64'hA0 + 64'(i % 4), 1'b1));
            tick();
        end
        chk("rr_cnt", FW'(pkt_count), 5);

        // rr_ptr is now 1: req1 sends a 3-flit packet while req2 waits.
        valid = 4'b0110;
        fl[1] = mk(64'hB1, 1'b0);
        fl[2] = mk(64'hC0, 1'b1);
        #1;
        chk("lk_g1",  FW'(grant), 4'b0010);
        chk("lk_d1",  inbits, mk(64'hB1, 1'b0));
        tick();
        fl[1] = mk(64'hB2, 1'b0);
        #1;
        chk("lk_l1",  FW'(locked), 1);
        chk("lk_g2",  FW'(grant), 4'b0010);
        chk("lk_d2",  inbits, mk(64'hB2, 1'b0));
        tick();
        fl[1] = mk(64'hB3, 1'b1);
        #1;
        chk("lk_l2",  FW'(locked), 1);
        chk("lk_g3",  FW'(grant), 4'b0010);
        chk("lk_r3",  FW'(ready), 4'b0010);
        tick();
        valid = 4'b0100;
        #1;
        chk("lk_unl", FW'(locked), 0);
        chk("lk_g4",  FW'(grant), 4'b0100);
        chk("lk_d4",  inbits, mk(64'hC0, 1'b1));
        chk("lk_cnt", FW'(pkt_count), 6);
        tick();

        // rr_ptr is 3. req0 starts a packet alone, then bubbles for 2 cycles.
        valid = 4'b0001;
        fl[0] = mk(64'hD1, 1'b0);
        fl[3] = mk(64'hE0, 1'b1);
        #1;
        chk("bb_g0", FW'(grant), 4'b0001);
        tick();
        valid = 4'b1000;
        for (int i = 0; i < 2; i++) begin
            #1;
            chk("bb_wen",   FW'(wen), 0);
            chk("bb_grant", FW'(grant), 4'b0001);
            chk("bb_ready", FW'(ready), 0);
            tick();
        end
        valid = 4'b1001;
        fl[0] = mk(64'hD2, 1'b1);
        #1;
        chk("bb_tailg", FW'(grant), 4'b0001);
        chk("bb_tailw", FW'(wen), 1);
        chk("bb_taild", inbits, mk(64'hD2, 1'b1));
        tick();
        valid = 4'b1000;
        #1;
        chk("bb_g3",  FW'(grant), 4'b1000);
        chk("bb_cnt", FW'(pkt_count), 8);
        tick();

        // rr_ptr is 0. req2 packet with the tail stalled by full for 3 cycles.
        valid = 4'b0100;
        fl[2] = mk(64'hF1, 1'b0);
        #1;
        chk("fs_g1", FW'(grant), 4'b0100);
        tick();
        fl[2] = mk(64'hF2, 1'b1);
        full  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("fs_wen",   FW'(wen), 0);
            chk("fs_ready", FW'(ready), 0);
            chk("fs_grant", FW'(grant), 4'b0100);
            chk("fs_cnt",   FW'(pkt_count), 9);
            tick();
        end
        full = 1'b0;
        #1;
        chk("fs_wen1",  FW'(wen), 1);
        chk("fs_rdy1",  FW'(ready), 4'b0100);
        chk("fs_data",  inbits, mk(64'hF2, 1'b1));
        tick();
        chk("fs_cnt2",  FW'(pkt_count), 10);
        chk("fs_unl",   FW'(locked), 0);

        // rr_ptr is 3. req3 head flit, then reset drops the lock.
        valid = 4'b1000;
        fl[3] = mk(64'h31, 1'b0);
        #1;
        chk("rm_g3", FW'(grant), 4'b1000);
        tick();
        chk("rm_lk", FW'(locked), 1);
        rst = 1'b1;
        #2;
        chk("rm_rstg", FW'(grant), 0);
        chk("rm_rstd", inbits, '0);
        rst = 1'b0;
        valid = 4'b1001;
        fl[0] = mk(64'h01, 1'b1);
        fl[3] = mk(64'h32, 1'b1);
        #1;
        chk("rm_unl",  FW'(locked), 0);
        chk("rm_cnt0", FW'(pkt_count), 0);
        chk("rm_ptr0", FW'(grant), 4'b0001);
        valid = 4'b1000;
        #1;
        chk("rm_g3b",  FW'(grant), 4'b1000);
        tick();
        valid = 4'b1001;
        #1;
        chk("rm_wrap", FW'(grant), 4'b0001);
        chk("rm_cnt1", FW'(pkt_count), 1);
        valid = 4'b0000;
        tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
